ram_arbiter: RTL and testbench



---
 rtl/ram_arb_pkg.sv | 11 +
 rtl/ram_arbiter.sv | 114 +++++++++++
 tb/tb_ram_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and parameter defaults for the RAM data-port arbiter.
package ram_arb_pkg;

  localparam int unsigned     ADDR_W_DEF   = 12;
  localparam int unsigned     DATA_W_DEF   = 32;
  localparam logic [11:0]     KBD_ADDR_DEF = 12'd25;

  typedef enum logic {IDLE, RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_IO} owner_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the RAM data port between the CPU load/store unit and the I/O agent:
// fixed CPU priority, starvation guard for I/O, CPU stores to the keyboard word dropped.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W       = ADDR_W_DEF,
  parameter int unsigned       DATA_W       = DATA_W_DEF,
  parameter int unsigned       STARVE_LIMIT = 4,
  parameter logic [ADDR_W-1:0] KBD_ADDR     = ADDR_W'(KBD_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int unsigned     CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t              state_q;
  owner_t              owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    starve_cnt;

  logic                any_req;
  logic                io_wins;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  assign any_req   = cpu_req | io_req;
  assign io_wins   = io_req & (~cpu_req | (starve_cnt == LIMIT));
  assign win_addr  = io_wins ? io_addr : cpu_addr;
  assign win_wdata = io_wins ? io_wdata : cpu_wdata;
  // CPU stores to the keyboard word never reach the RAM but are still acked.
  assign win_we    = io_wins ? io_we : (cpu_we & (cpu_addr != KBD_ADDR));

  // Outputs are forced quiet while rst is high, including an aborted RESP.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    cpu_ack   = 1'b0;
    io_ack    = 1'b0;
    cpu_rdata = '0;
    io_rdata  = '0;
    busy      = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            ram_addr  = win_addr;
            ram_wdata = win_wdata;
            ram_we    = win_we;
          end
        end
        RESP: begin
          busy     = 1'b1;
          ram_addr = addr_q;
          if (owner_q == OWN_CPU) begin
            cpu_ack = 1'b1;
            if (!we_q) cpu_rdata = ram_rdata;
          end else begin
            io_ack = 1'b1;
            if (!we_q) io_rdata = ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      we_q       <= 1'b0;
      addr_q     <= '0;
      starve_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!io_req || io_wins) starve_cnt <= '0;
          else if (cpu_req && starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
          if (any_req) begin
            state_q <= RESP;
            owner_q <= io_wins ? OWN_IO : OWN_CPU;
            we_q    <= io_wins ? io_we : cpu_we;
            addr_q  <= win_addr;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model with its own shadow memory.
module tb_ram_arbiter;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int          LIM = 4;
  localparam logic [11:0] KBD = 12'd25;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          io_req = 1'b0, io_we = 1'b0;
  logic [AW-1:0] io_addr = '0;
  logic [DW-1:0] io_wdata = '0;
  logic          io_ack;
  logic [DW-1:0] io_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .KBD_ADDR(KBD)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read, as seen by the arbiter.
  bit [DW-1:0] ram [4096];
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // Reference model state: shadow memory, last grant and its attributes.
  bit [DW-1:0] mem_ref [4096];
  int          tests = 0, fails = 0, cyc = 0;
  int          last_grant = -10, streak = 0;
  bit          m_io, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rd;
  bit          ack_cpu_m = 1'b0, ack_io_m = 1'b0;
  int          cpu_ack_cyc = -1, io_ack_cyc = -1, io_ack_first = -1;
  logic [DW-1:0] obs_cpu_rd, obs_io_rd;
  bit          ack_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    chk({tag, "_io_ack"}, 32'(io_ack), 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_io_rdata"}, io_rdata, 32'd0);
  endtask

  // One clock cycle: settle inputs, compare against the model, advance.
  task automatic step();
    bit            io_w, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    #1;
    ack_cpu_m = 1'b0;
    ack_io_m  = 1'b0;
    if (cpu_ack) begin cpu_ack_cyc = cyc; obs_cpu_rd = cpu_rdata; ack_log.push_back(1'b0); end
    if (io_ack) begin
      io_ack_cyc = cyc; obs_io_rd = io_rdata; ack_log.push_back(1'b1);
      if (io_ack_first < 0) io_ack_first = cyc;
    end
    if (rst) begin
      chk_quiet("rst");
      last_grant = -10;
      streak     = 0;
    end else if (last_grant == cyc - 1) begin
      chk("resp_busy", 32'(busy), 32'd1);
      chk("resp_ram_we", 32'(ram_we), 32'd0);
      chk("resp_ram_addr", 32'(ram_addr), 32'(m_addr));
      chk("resp_cpu_ack", 32'(cpu_ack), 32'(!m_io));
      chk("resp_io_ack", 32'(io_ack), 32'(m_io));
      chk("resp_cpu_rdata", cpu_rdata, (!m_io && !m_we) ? m_rd : 32'd0);
      chk("resp_io_rdata", io_rdata, (m_io && !m_we) ? m_rd : 32'd0);
      ack_cpu_m = !m_io;
      ack_io_m  = m_io;
    end else begin
      if (!io_req) streak = 0;
      if (cpu_req || io_req) begin
        io_w   = io_req && (!cpu_req || streak >= LIM);
        e_addr = io_w ? io_addr : cpu_addr;
        e_wd   = io_w ? io_wdata : cpu_wdata;
        e_we   = io_w ? io_we : (cpu_we && cpu_addr != KBD);
        chk("g_ram_we", 32'(ram_we), 32'(e_we));
        chk("g_ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("g_ram_wdata", ram_wdata, e_wd);
        chk("g_busy", 32'(busy), 32'd0);
        chk("g_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("g_io_ack", 32'(io_ack), 32'd0);
        m_io   = io_w;
        m_we   = io_w ? io_we : cpu_we;
        m_addr = e_addr;
        m_rd   = mem_ref[e_addr];
        last_grant = cyc;
        if (e_we) mem_ref[e_addr] = e_wd;
        if (io_w) streak = 0;
        else if (io_req) streak = (streak < LIM) ? streak + 1 : LIM;
      end else begin
        chk_quiet("idle");
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic txn(input bit io, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (io) begin io_we = we; io_addr = a; io_wdata = d; io_req = 1'b1; end
    else begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
    ack_cpu_m = 1'b0;
    ack_io_m  = 1'b0;
    for (int i = 0; i < 6 && !(io ? ack_io_m : ack_cpu_m); i++) step();
    chk(io ? "io_txn_ack_cycle" : "cpu_txn_ack_cycle",
        io ? io_ack_cyc : cpu_ack_cyc, cyc - 1);
    if (io) io_req = 1'b0; else cpu_req = 1'b0;
  endtask

  task automatic new_cpu();
    cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
    cpu_addr = AW'($urandom_range(20, 31)); cpu_wdata = $urandom;
  endtask

  task automatic new_io();
    io_req = 1'b1; io_we = 1'($urandom_range(0, 1));
    io_addr = AW'($urandom_range(20, 31)); io_wdata = $urandom;
  endtask

  initial begin
    bit exp_order [10];
    int g0;
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    @(posedge clk);
    #1;
    // Reset holds everything quiet even with a pending CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd42; cpu_wdata = 32'h5;
    repeat (3) step();
    rst = 1'b0; cpu_req = 1'b0;
    repeat (2) step();

    txn(1'b0, 1'b1, 12'd42, 32'hDEADBEEF);
    txn(1'b0, 1'b0, 12'd42, 32'd0);
    chk("rd42", obs_cpu_rd, 32'hDEADBEEF);

    txn(1'b0, 1'b1, KBD, 32'h1234);
    txn(1'b1, 1'b1, KBD, 32'h41);
    txn(1'b0, 1'b0, KBD, 32'd0);
    chk("rd_kbd", obs_cpu_rd, 32'h41);

    // Both requesters saturating the port.
    step();
    cpu_we = 1'b0; cpu_addr = 12'd30; cpu_req = 1'b1;
    io_we = 1'b0; io_addr = 12'd31; io_req = 1'b1;
    ack_log.delete();
    io_ack_first = -1;
    g0 = cyc;
    repeat (20) step();
    cpu_req = 1'b0; io_req = 1'b0;
    chk("order_len", 32'(ack_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < ack_log.size(); i++)
      chk($sformatf("order_%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));
    chk("io_wait", io_ack_first - g0, 32'd9);

    // Simultaneous requests with the counter cleared.
    step();
    cpu_we = 1'b1; cpu_addr = 12'd50; cpu_wdata = 32'd77; cpu_req = 1'b1;
    io_we = 1'b0; io_addr = 12'd42; io_req = 1'b1;
    step();
    step();
    cpu_req = 1'b0;
    step();
    step();
    io_req = 1'b0;
    chk("simul_gap", io_ack_cyc - cpu_ack_cyc, 32'd2);
    chk("simul_io_rd", obs_io_rd, 32'hDEADBEEF);

    // Reset during the RESP of a write: no ack, but the write persists.
    cpu_we = 1'b1; cpu_addr = 12'd43; cpu_wdata = 32'hCAFEF00D; cpu_req = 1'b1;
    step();
    rst = 1'b1; cpu_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    txn(1'b0, 1'b0, 12'd43, 32'd0);
    chk("rd43_after_rst", obs_cpu_rd, 32'hCAFEF00D);

    for (int n = 0; n < 600; n++) begin
      if (!cpu_req && $urandom_range(0, 2) == 0) new_cpu();
      if (!io_req && $urandom_range(0, 2) == 0) new_io();
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; cpu_req = 1'b0; io_req = 1'b0;
      end else begin
        rst = 1'b0;
      end
      step();
      if (ack_cpu_m) begin
        if ($urandom_range(0, 1) == 1) new_cpu(); else cpu_req = 1'b0;
      end
      if (ack_io_m) begin
        if ($urandom_range(0, 1) == 1) new_io(); else io_req = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
